// File: rtl/booth_mult_ctrl_pkg.sv
// booth_mult_ctrl_pkg: shared FSM encodings, Booth select codes and defaults
package booth_mult_ctrl_pkg;
    localparam int ITERATIONS_DEF = 32;
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;
    localparam logic [1:0] SEL_NOP = 2'b00;
    localparam logic [1:0] SEL_ADD = 2'b01;
    localparam logic [1:0] SEL_SUB = 2'b10;
endpackage

// File: rtl/booth_mult_ctrl_if.sv
// booth_mult_ctrl_if: start/operand request and result/status response of the multiplier
// master drives ctrl_MULT and both operands; slave drives result, exception, ready pulse and busy
interface booth_mult_ctrl_if;
    logic        ctrl_MULT;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;
    modport master (output ctrl_MULT, data_operandA, data_operandB,
                    input  data_result, data_exception, data_resultRDY, busy);
    modport slave  (input  ctrl_MULT, data_operandA, data_operandB,
                    output data_result, data_exception, data_resultRDY, busy);
endinterface

// File: rtl/booth_mult_ctrl_booth_step.sv
// booth_step: one radix-2 Booth iteration (add/sub/nop on HI, then arithmetic shift right)
// ports: sel={LO[0],Qm1}, m, hi, lo in; next hi_n, lo_n, qm1_n out
module booth_step
    import booth_mult_ctrl_pkg::*;
(
    input  logic [1:0]  sel,
    input  logic [31:0] m,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] hi_n,
    output logic [31:0] lo_n,
    output logic        qm1_n
);
    logic [31:0] addend, s;
    logic        c0, c32, s32;
    assign addend = sel == SEL_SUB ? ~m : sel == SEL_ADD ? m : 32'd0;
    assign c0     = sel == SEL_SUB;
    cla_32bit u_cla (.a(hi), .b(addend), .c0(c0), .s(s), .c32(c32));
    // 33rd sum bit is the exact sign of HI+addend+c0, so even -0x80000000 shifts correctly
    assign s32 = hi[31] ^ addend[31] ^ c32;
    assign {hi_n, lo_n, qm1_n} = {s32, s, lo};
endmodule

// cla_32bit: 32-bit adder of 4-bit carry-lookahead groups; ports a, b, c0 in; s, c32 out
module cla_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c0,
    output logic [31:0] s,
    output logic        c32
);
    logic [31:0] g, p;
    logic [8:0]  c;
    assign g    = a & b;
    assign p    = a ^ b;
    assign c[0] = c0;
    assign c32  = c[8];
    for (genvar k = 0; k < 8; k++) begin : grp
        logic [3:0] gg, pp;
        logic [4:0] cc;
        assign gg    = g[4*k +: 4];
        assign pp    = p[4*k +: 4];
        assign cc[0] = c[k];
        assign cc[1] = gg[0] | (pp[0] & cc[0]);
        assign cc[2] = gg[1] | (pp[1] & gg[0]) | (&pp[1:0] & cc[0]);
        assign cc[3] = gg[2] | (pp[2] & gg[1]) | (&pp[2:1] & gg[0]) | (&pp[2:0] & cc[0]);
        assign cc[4] = gg[3] | (pp[3] & gg[2]) | (&pp[3:2] & gg[1]) | (&pp[3:1] & gg[0])
                     | (&pp[3:0] & cc[0]);
        assign s[4*k +: 4] = pp ^ cc[3:0];
        assign c[k+1]      = cc[4];
    end
endmodule

// File: rtl/booth_mult_ctrl.sv
// booth_mult_ctrl: sequential signed 32x32 Booth multiplier sharing one CLA adder
// ports: clock, reset (sync, active high); bus (slave) carries start/operands and result/status
module booth_mult_ctrl
    import booth_mult_ctrl_pkg::*;
#(
    parameter int ITERATIONS = ITERATIONS_DEF,
    parameter int CNT_W      = 5
)(
    input  logic clock,
    input  logic reset,
    booth_mult_ctrl_if.slave bus
);
    logic [1:0]       state;
    logic [31:0]      m, hi, lo, hi_n, lo_n, result;
    logic             qm1, qm1_n, exc, rdy;
    logic [CNT_W-1:0] cnt;
    booth_step u_step (
        .sel   ({lo[0], qm1}),
        .m     (m),
        .hi    (hi),
        .lo    (lo),
        .hi_n  (hi_n),
        .lo_n  (lo_n),
        .qm1_n (qm1_n)
    );
    assign bus.data_result    = result;
    assign bus.data_exception = exc;
    assign bus.data_resultRDY = rdy;
    assign bus.busy           = state == ST_RUN;
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= ST_IDLE;
            m      <= '0;
            hi     <= '0;
            lo     <= '0;
            qm1    <= 1'b0;
            cnt    <= '0;
            result <= '0;
            exc    <= 1'b0;
            rdy    <= 1'b0;
        end else begin
            rdy <= 1'b0;
            // a start in any state restarts; an aborted operation never reports
            if (bus.ctrl_MULT) begin
                state <= ST_RUN;
                m     <= bus.data_operandA;
                hi    <= '0;
                lo    <= bus.data_operandB;
                qm1   <= 1'b0;
                cnt   <= '0;
            end else if (state == ST_RUN) begin
                {hi, lo, qm1} <= {hi_n, lo_n, qm1_n};
                cnt           <= cnt + 1'b1;
                if (cnt == CNT_W'(ITERATIONS - 1))
                    state <= ST_DONE;
            end else if (state == ST_DONE) begin
                result <= lo;
                exc    <= hi != {32{lo[31]}};
                rdy    <= 1'b1;
                state  <= ST_IDLE;
            end
        end
    end
endmodule
